board_display_sched: RTL and testbench

//  Selects which debug page drives the board's 8 HEX digits and 8 green LEDs.

---
 rtl/board_display_sched_pkg.sv | 23 ++
 rtl/board_display_sched_key_debounce.sv | 48 ++++
 rtl/board_display_sched.sv | 188 ++++++++++++++++++
 tb/tb_board_display_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_display_sched_pkg.sv
// Shared constants, state encoding and helpers for the board debug display.
package board_disp_pkg;

   localparam int NPAGES = 4;
   localparam int PAGE_W = 32;
   localparam int FLAG_W = 8;

   typedef enum logic {
      ST_LIVE   = 1'b0,
      ST_FROZEN = 1'b1
   } disp_state_e;

   localparam logic [1:0] PAGE_CPU = 2'd0;
   localparam logic [1:0] PAGE_PPU = 2'd1;
   localparam logic [1:0] PAGE_MAP = 2'd2;
   localparam logic [1:0] PAGE_AUX = 2'd3;

   // Width of a counter that must hold values 0 .. n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/board_display_sched_key_debounce.sv
// Raw active-low key -> 2-flop synchronizer -> stability counter -> press pulse.
// A level is accepted only after it has differed from the accepted level for
// DEBOUNCE_CYC consecutive cycles; accepting a 1->0 change emits one pulse.
module key_debounce
   import board_disp_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_raw,
   output logic o_press
);

   localparam int             CW       = cnt_width(DEBOUNCE_CYC);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   logic [1:0]    sync_r;
   logic          level_r;
   logic [CW-1:0] cnt_r;
   logic          press_r;

   // Synchronize the key, count stable-difference cycles, accept and pulse.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_r  <= 2'b11;
         level_r <= 1'b1;
         cnt_r   <= '0;
         press_r <= 1'b0;
      end else begin
         sync_r  <= {sync_r[0], i_key_raw};
         press_r <= 1'b0;
         if (sync_r[1] == level_r) begin
            cnt_r <= '0;
         end else if (cnt_r == CNT_LAST) begin
            level_r <= sync_r[1];
            cnt_r   <= '0;
            press_r <= ~sync_r[1];
         end else begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   assign o_press = press_r;

endmodule

// File: rtl/board_display_sched.sv
// Debug page selector for the board's HEX digits and green LEDs: page stepping
// (manual or timed), freeze/unfreeze of a full snapshot, registered outputs.
module board_display_sched
   import board_disp_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 500000,
   parameter int AUTO_CYC     = 100000000
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_key_next,
   input  logic                       i_key_freeze,
   input  logic                       i_sw_auto,
   input  logic [NPAGES*PAGE_W-1:0]   i_pages,
   input  logic [NPAGES*FLAG_W-1:0]   i_flags,
   output logic [PAGE_W-1:0]          o_hex_word,
   output logic [FLAG_W-1:0]          o_ledg,
   output logic [1:0]                 o_page,
   output logic                       o_frozen
);

   localparam int            AW        = cnt_width(AUTO_CYC);
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_CYC - 1);
   localparam logic [AW-1:0] AUTO_ONE  = AW'(1);

   logic                      next_press_s;
   logic                      freeze_press_s;
   logic [1:0]                sw_sync_r;
   disp_state_e               state_r;
   disp_state_e               state_nx_s;
   logic                      capture_s;
   logic [1:0]                page_r;
   logic [AW-1:0]             auto_cnt_r;
   logic                      auto_run_s;
   logic                      auto_tick_s;
   logic                      advance_s;
   logic [NPAGES*PAGE_W-1:0]  snap_pages_r;
   logic [NPAGES*FLAG_W-1:0]  snap_flags_r;
   logic [PAGE_W-1:0]         sel_word_s;
   logic [FLAG_W-1:0]         sel_flag_s;

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_next (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_key_raw (i_key_next),
      .o_press   (next_press_s)
   );

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_freeze (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_key_raw (i_key_freeze),
      .o_press   (freeze_press_s)
   );

   // The auto-scroll switch only needs synchronizing; it is a level, not a press.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sw_sync_r <= 2'b00;
      end else begin
         sw_sync_r <= {sw_sync_r[0], i_sw_auto};
      end
   end

   // Dwell timer enable and end-of-dwell tick.
   always_comb begin
      auto_run_s  = 1'b0;
      auto_tick_s = 1'b0;
      if (sw_sync_r[1] && (state_r == ST_LIVE)) begin
         auto_run_s  = 1'b1;
         auto_tick_s = (auto_cnt_r == AUTO_LAST);
      end else begin
         auto_run_s  = 1'b0;
         auto_tick_s = 1'b0;
      end
   end

   assign advance_s = next_press_s | auto_tick_s;

   // Dwell counter: a manual step restarts the dwell so the user gets a full page time.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         auto_cnt_r <= '0;
      end else if (!auto_run_s || next_press_s) begin
         auto_cnt_r <= '0;
      end else if (auto_cnt_r == AUTO_LAST) begin
         auto_cnt_r <= '0;
      end else begin
         auto_cnt_r <= auto_cnt_r + AUTO_ONE;
      end
   end

   // Page index steps once per cycle with any advance source, wrapping naturally.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         page_r <= PAGE_CPU;
      end else if (advance_s) begin
         page_r <= page_r + 2'd1;
      end else begin
         page_r <= page_r;
      end
   end

   // Freeze FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r <= ST_LIVE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Freeze FSM next state; capture only on the LIVE -> FROZEN transition.
   always_comb begin
      state_nx_s = state_r;
      capture_s  = 1'b0;
      case (state_r)
         ST_LIVE: begin
            if (freeze_press_s) begin
               state_nx_s = ST_FROZEN;
               capture_s  = 1'b1;
            end else begin
               state_nx_s = ST_LIVE;
            end
         end
         ST_FROZEN: begin
            if (freeze_press_s) begin
               state_nx_s = ST_LIVE;
            end else begin
               state_nx_s = ST_FROZEN;
            end
         end
         default: begin
            state_nx_s = ST_LIVE;
         end
      endcase
   end

   // Snapshot of every page and flag word, taken from the inputs of the freeze cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         snap_pages_r <= '0;
         snap_flags_r <= '0;
      end else if (capture_s) begin
         snap_pages_r <= i_pages;
         snap_flags_r <= i_flags;
      end else begin
         snap_pages_r <= snap_pages_r;
         snap_flags_r <= snap_flags_r;
      end
   end

   // Select the displayed slice from live inputs or the snapshot.
   always_comb begin
      sel_word_s = '0;
      sel_flag_s = '0;
      case (state_r)
         ST_LIVE: begin
            sel_word_s = i_pages[{page_r, 5'd0} +: PAGE_W];
            sel_flag_s = i_flags[{page_r, 3'd0} +: FLAG_W];
         end
         ST_FROZEN: begin
            sel_word_s = snap_pages_r[{page_r, 5'd0} +: PAGE_W];
            sel_flag_s = snap_flags_r[{page_r, 3'd0} +: FLAG_W];
         end
         default: begin
            sel_word_s = '0;
            sel_flag_s = '0;
         end
      endcase
   end

   // Output registers: data, page and freeze flag all derive from the same state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_hex_word <= '0;
         o_ledg     <= '0;
         o_page     <= 2'd0;
         o_frozen   <= 1'b0;
      end else begin
         o_hex_word <= sel_word_s;
         o_ledg     <= sel_flag_s;
         o_page     <= page_r;
         o_frozen   <= (state_r == ST_FROZEN);
      end
   end

endmodule

// File: tb/tb_board_display_sched.sv
// Randomized scoreboard bench for board_display_sched (DEBOUNCE_CYC=4, AUTO_CYC=10).
module tb_board_display_sched;

   localparam int DEB  = 4;
   localparam int AUTO = 10;
   localparam int HOLD = 8;   // sync(2) + debounce(4) + pulse(1) + output(1)

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_key_next;
   logic          i_key_freeze;
   logic          i_sw_auto;
   logic [127:0]  i_pages;
   logic [31:0]   i_flags;
   logic [31:0]   o_hex_word;
   logic [7:0]    o_ledg;
   logic [1:0]    o_page;
   logic          o_frozen;

   board_display_sched #(.DEBOUNCE_CYC(DEB), .AUTO_CYC(AUTO)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_key_next   (i_key_next),
      .i_key_freeze (i_key_freeze),
      .i_sw_auto    (i_sw_auto),
      .i_pages      (i_pages),
      .i_flags      (i_flags),
      .o_hex_word   (o_hex_word),
      .o_ledg       (o_ledg),
      .o_page       (o_page),
      .o_frozen     (o_frozen)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      string       name;
      logic [1:0]  page;
      logic        frozen;
      logic [31:0] hex;
      logic [7:0]  ledg;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   // Reference model: what the user should see, in terms of the board's rules.
   logic [31:0] m_pages [4];
   logic [7:0]  m_flags [4];
   logic [31:0] s_pages [4];
   logic [7:0]  s_flags [4];
   int          m_page;
   bit          m_frozen;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < 4; i++) begin
         i_pages[32*i +: 32] = m_pages[i];
         i_flags[8*i +: 8]   = m_flags[i];
      end
   endtask

   task automatic randomize_inputs();
      for (int i = 0; i < 4; i++) begin
         m_pages[i] = $urandom;
         m_flags[i] = 8'($urandom);
      end
      drive_inputs();
   endtask

   task automatic model_reset();
      m_page   = 0;
      m_frozen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_pages[i] = 32'h0;
         s_flags[i] = 8'h0;
      end
   endtask

   task automatic step_page();
      m_page = (m_page + 1) % 4;
   endtask

   task automatic expect_state(input string name);
      exp_t e;
      e.name   = name;
      e.page   = 2'(m_page);
      e.frozen = m_frozen;
      e.hex    = m_frozen ? s_pages[m_page] : m_pages[m_page];
      e.ledg   = m_frozen ? s_flags[m_page] : m_flags[m_page];
      exp_q.push_back(e);
   endtask

   task automatic expect_zero(input string name);
      exp_t e;
      e.name   = name;
      e.page   = 2'd0;
      e.frozen = 1'b0;
      e.hex    = 32'h0;
      e.ledg   = 8'h0;
      exp_q.push_back(e);
   endtask

   task automatic press_next();
      i_key_next = 1'b0;
      tick(HOLD);
      step_page();
      i_key_next = 1'b1;
      tick(HOLD);
   endtask

   task automatic press_freeze();
      i_key_freeze = 1'b0;
      tick(HOLD);
      if (!m_frozen) begin
         s_pages = m_pages;
         s_flags = m_flags;
      end
      m_frozen = !m_frozen;
      i_key_freeze = 1'b1;
      tick(HOLD);
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual=%h required=%h", nm, act, req);
      end
   endtask

   // Monitor: compares every queued expectation against the outputs mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cmp({e.name, ".page"},   32'(o_page),     32'(e.page));
            cmp({e.name, ".frozen"}, 32'(o_frozen),   32'(e.frozen));
            cmp({e.name, ".hex"},    o_hex_word,      e.hex);
            cmp({e.name, ".ledg"},   32'(o_ledg),     32'(e.ledg));
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_rst        = 1'b1;
      i_key_next   = 1'b1;
      i_key_freeze = 1'b1;
      i_sw_auto    = 1'b0;
      model_reset();
      randomize_inputs();
      tick(2);
      expect_zero("reset_state");
      tick(1);
      i_rst = 1'b0;
      tick(1);
      expect_state("reset_release_live");
      tick(1);

      // Clean press onto page 1 with known content.
      m_pages[1] = 32'h1234_ABCD;
      m_flags[1] = 8'h5A;
      drive_inputs();
      press_next();
      expect_state("clean_press");
      tick(1);

      // Wrap: from page 3, four presses give 0,1,2,3.
      while (m_page != 3) press_next();
      expect_state("at_page3");
      for (int k = 0; k < 4; k++) begin
         press_next();
         expect_state($sformatf("wrap_seq%0d", k));
         tick(1);
      end

      // Bouncing next key, then a solid hold: one step, 8 cycles after the hold.
      for (int k = 0; k < 10; k++) begin
         i_key_next = (k % 2 == 0) ? 1'b0 : 1'b1;
         tick(2);
      end
      expect_state("bounce_no_step");
      i_key_next = 1'b0;
      tick(7);
      expect_state("bounce_hold7");
      tick(1);
      step_page();
      expect_state("bounce_hold8");
      i_key_next = 1'b1;
      tick(HOLD);

      // Freeze keeps the snapshot; browsing and unfreezing.
      while (m_page != 0) press_next();
      m_pages[0] = 32'h0000_C000;
      drive_inputs();
      tick(1);
      expect_state("live_c000");
      press_freeze();
      expect_state("frozen_capture");
      m_pages[0] = 32'hFFFF_0000;
      drive_inputs();
      tick(1);
      expect_state("frozen_hold");
      press_next();
      expect_state("snap_page1");
      press_freeze();
      expect_state("unfrozen_page1");
      while (m_page != 0) press_next();
      expect_state("live_ffff0000");
      tick(1);

      // Auto-scroll every AUTO cycles; coincident press and tick step once.
      i_sw_auto = 1'b1;
      tick(12);
      expect_state("auto_before");
      tick(1);
      step_page();
      expect_state("auto_step1");
      tick(9);
      expect_state("auto_dwell");
      tick(1);
      step_page();
      expect_state("auto_step2");
      tick(2);
      i_key_next = 1'b0;
      tick(7);
      expect_state("coinc_before");
      tick(1);
      step_page();
      expect_state("coinc_plus1");
      i_key_next = 1'b1;
      tick(9);
      expect_state("auto_after_coinc");
      tick(1);
      step_page();
      expect_state("auto_step3");
      press_freeze();
      expect_state("auto_frozen");
      tick(30);
      expect_state("auto_frozen_stays");
      i_sw_auto = 1'b0;
      tick(1);
      press_freeze();
      expect_state("auto_unfrozen");
      tick(1);

      // Randomized mix of input changes, presses and freezes.
      for (int k = 0; k < 24; k++) begin
         case ($urandom_range(0, 2))
            0: begin
               randomize_inputs();
               tick(1);
            end
            1: press_next();
            default: press_freeze();
         endcase
         expect_state($sformatf("rand%0d", k));
         tick(1);
      end

      // Reset mid-run while on page 2 and frozen.
      while (m_page != 2) press_next();
      if (!m_frozen) press_freeze();
      expect_state("pre_reset");
      tick(1);
      i_rst = 1'b1;
      model_reset();
      expect_zero("midrun_reset");
      tick(1);
      i_rst = 1'b0;
      tick(1);
      expect_state("after_midrun_reset");
      tick(2);

      n_total++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL drain: actual=%0d required=0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
